i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

Command queue and launch sequencer sitting directly upstream of the I2C master. Host logic pushes {address, rw, data} transactions into a small FIFO. The sequencer drains the FIFO one transaction at a time: it drives the master's enable/address/rw/data inputs, waits for the master's busy flag to rise and then fall, and pops the entry on completion. It removes the need for the host to hand-time `enable` pulses against `busy`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 7: I2C target address width.
- `DATA_W`, 8: payload byte width.
- `BUSY_TIMEOUT`, 16: cycles to wait for `i_busy` to rise after launch.

Ports:
- `i_clk`  in  1: system clock, rising edge.
- `i_rst_n`  in  1: reset, synchronous, active-low.
- `i_push`  in  1: enqueue request.
- `i_cmd_addr`  in  ADDR_W: address for pushed command.
- `i_cmd_rw`  in  1: 0 = write, 1 = read.
- `i_cmd_data`  in  DATA_W: write byte for pushed command.
- `o_full`  out  1: FIFO holds DEPTH entries.
- `o_empty`  out  1: FIFO holds 0 entries.
- `o_count`  out  $clog2(DEPTH)+1: current occupancy.
- `o_overflow`  out  1: one-cycle pulse, push dropped.
- `o_enable`  out  1: to master `i_enable`.
- `o_address`  out  ADDR_W: to master `i_address`.
- `o_rw`  out  1: to master `i_rw`.
- `o_data`  out  DATA_W: to master `i_data`.
- `i_busy`  in  1: from master `o_busy`, same clock domain.
- `o_done`  out  1: one-cycle pulse, transaction completed and popped.
- `o_timeout`  out  1: one-cycle pulse, master never went busy; entry discarded.

## Operation
- Reset (`i_rst_n` = 0 at an edge): FIFO pointers and count are cleared; FSM goes to IDLE. Reset values: `o_enable`/`o_address`/`o_rw`/`o_data`/`o_done`/`o_timeout`/`o_overflow` = 0, `o_empty` = 1, `o_full` = 0, `o_count` = 0. Reset applied mid-transaction abandons it with no `o_done`.
- Push: accepted when `i_push` is high and `o_full` is low, sampled at the edge. Push while full is dropped and pulses `o_overflow` the next cycle. This holds even if a pop occurs in the same cycle (full is evaluated before the pop).
- Simultaneous push and pop when not full: both take effect; count is unchanged.
- FSM states:
  - IDLE: if `o_empty` = 0, latch the head entry into `o_address`/`o_rw`/`o_data`, set `o_enable` = 1, and go to LAUNCH.
  - LAUNCH: hold `o_enable` = 1 and count cycles. If `i_busy` = 1, set `o_enable` = 0 and go to WAIT_DONE. If the count reaches `BUSY_TIMEOUT`, set `o_enable` = 0, pop, pulse `o_timeout`, and go to IDLE.
  - WAIT_DONE: hold the outputs stable. When `i_busy` = 0, pop, pulse `o_done`, and go to IDLE.
- `o_address`/`o_rw`/`o_data` remain stable from LAUNCH entry until the next launch. They are never changed while `i_busy` = 1.
- Pointer arithmetic wraps modulo DEPTH. Count is DEPTH+1-valued (0..DEPTH).

## Timing
- Push at edge N: `o_empty` falls and `o_count` increments at N+1. The FSM in IDLE sees the entry and `o_enable` rises at edge N+2 (push-to-enable latency is 2 cycles from an idle, empty state).
- `o_enable` falls on the edge after `i_busy` is first sampled high.
- `i_busy` sampled low in WAIT_DONE at edge M: `o_done` is high and count is decremented during cycle M+1. The next queued entry launches at M+2 at the earliest.
- Minimum gap between consecutive `o_enable` assertions is 1 low cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `i2c_pkg`: FSM state encoding (IDLE, LAUNCH, WAIT_DONE) and the command record width (ADDR_W+1+DATA_W). This package is shared with master/slave constants.
- Sub-module `i2c_cmd_fifo`: synchronous FIFO with push, pop, full, empty, count, and head data. The top level contains the FSM and timeout counter only.

## Test plan
- Single write: push addr 7'h66, rw 0, data 8'hE3 into an empty queue; master busy rises 3 cycles later and lasts 40 cycles → `o_enable` rises 2 cycles after the push, drops the cycle after busy, and `o_done` pulses once; `o_empty` = 1 afterwards.
- Back-to-back: push 3 commands on consecutive cycles → 3 launches in FIFO order, each exactly one `o_done`, and outputs never change while busy = 1.
- Overflow: with DEPTH = 4 and the master held busy, push 5 entries → `o_full` = 1 after the 4th, `o_overflow` pulses once for the 5th, and `o_count` = 4.
- Timeout: push a command with `i_busy` tied to 0 → `o_enable` high for 16 cycles, then `o_timeout` pulses, the entry is popped, and there is no `o_done`.
- Reset mid-transaction: drive `i_rst_n` = 0 during WAIT_DONE with 2 entries queued → next cycle all outputs are at reset values, `o_count` = 0, and there is no `o_done`.
- Wrap-around: 10 push/complete cycles with DEPTH = 4 → data order is preserved across the pointer wrap.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: sequencer FSM encoding and command record sizing.
// Used by the command sequencer as well as the master/slave blocks.
package i2c_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LAUNCH,
        SEQ_WAIT_DONE
    } seq_state_e;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    // {address, rw, data}
    function automatic int cmd_width(input int addr_w, input int data_w);
        return addr_w + 1 + data_w;
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and overflow pulse.
// Full is judged before any same-cycle pop, so a push while full always drops.
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and launches them one at a time on the master,
// handshaking enable against busy and discarding commands the master ignores.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = I2C_ADDR_W,
    parameter int DATA_W       = I2C_DATA_W,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_cmd_addr,
    input  logic                     i_cmd_rw,
    input  logic [DATA_W-1:0]        i_cmd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_enable,
    output logic [ADDR_W-1:0]        o_address,
    output logic                     o_rw,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     i_busy,
    output logic                     o_done,
    output logic                     o_timeout
);

    localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
    localparam int TCW   = $clog2(BUSY_TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic              enable_d, rw_d, done_d, timeout_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] data_d;
    logic              pop;
    logic [CMD_W-1:0]  head;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (i_push),
        .pop      (pop),
        .wdata    ({i_cmd_addr, i_cmd_rw, i_cmd_data}),
        .full     (o_full),
        .empty    (o_empty),
        .count    (o_count),
        .head     (head),
        .overflow (o_overflow)
    );

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        enable_d  = o_enable;
        address_d = o_address;
        rw_d      = o_rw;
        data_d    = o_data;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (!o_empty) begin
                    {address_d, rw_d, data_d} = head;
                    enable_d = 1'b1;
                    tcnt_d   = '0;
                    state_d  = SEQ_LAUNCH;
                end
            end
            SEQ_LAUNCH: begin
                if (i_busy) begin
                    enable_d = 1'b0;
                    state_d  = SEQ_WAIT_DONE;
                end else if (tcnt_q == TCW'(BUSY_TIMEOUT - 1)) begin
                    // Master never answered: drop the command
                    enable_d  = 1'b0;
                    pop       = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = SEQ_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            SEQ_WAIT_DONE: begin
                if (!i_busy) begin
                    pop     = 1'b1;
                    done_d  = 1'b1;
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= SEQ_IDLE;
            tcnt_q    <= '0;
            o_enable  <= 1'b0;
            o_address <= '0;
            o_rw      <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            o_enable  <= enable_d;
            o_address <= address_d;
            o_rw      <= rw_d;
            o_data    <= data_d;
            o_done    <= done_d;
            o_timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for the I2C command sequencer with a scripted master.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_i2c_cmd_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_push;
    logic [6:0] i_cmd_addr;
    logic       i_cmd_rw;
    logic [7:0] i_cmd_data;
    logic       o_full;
    logic       o_empty;
    logic [2:0] o_count;
    logic       o_overflow;
    logic       o_enable;
    logic [6:0] o_address;
    logic       o_rw;
    logic [7:0] o_data;
    logic       i_busy;
    logic       o_done;
    logic       o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    i2c_cmd_sequencer dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (i_push),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_rw   (i_cmd_rw),
        .i_cmd_data (i_cmd_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_enable   (o_enable),
        .o_address  (o_address),
        .o_rw       (o_rw),
        .o_data     (o_data),
        .i_busy     (i_busy),
        .o_done     (o_done),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_one(input logic [6:0] a, input logic rw,
                            input logic [7:0] d);
        i_push     = 1'b1;
        i_cmd_addr = a;
        i_cmd_rw   = rw;
        i_cmd_data = d;
        step();
        i_push = 1'b0;
    endtask

    // Plays the master for one command: busy after dly cycles for len cycles.
    task automatic serve(input int dly, input int len, input logic [6:0] ea,
                         input logic erw, input logic [7:0] ed);
        int   n;
        logic bad;
        n = 0;
        while (!o_enable && n < 40) begin
            step();
            n++;
        end
        check("launch", o_enable, 1);
        check("addr", o_address, ea);
        check("rw", o_rw, erw);
        check("data", o_data, ed);
        repeat (dly) step();
        i_busy = 1'b1;
        step();
        check("en_drop", o_enable, 0);
        bad = 1'b0;
        repeat (len - 1) begin
            if ({o_address, o_rw, o_data} !== {ea, erw, ed} || o_enable)
                bad = 1'b1;
            step();
        end
        check("stable_busy", bad, 0);
        i_busy = 1'b0;
        step();
        check("done", o_done, 1);
        step();
        check("done_pulse", o_done, 0);
    endtask

    initial begin
        int n;
        i_rst_n    = 1'b0;
        i_push     = 1'b0;
        i_cmd_addr = '0;
        i_cmd_rw   = 1'b0;
        i_cmd_data = '0;
        i_busy     = 1'b0;
        repeat (3) step();
        i_rst_n = 1'b1;
        step();

        check("rst_enable", o_enable, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_count", o_count, 0);
        check("rst_flags", {o_done, o_timeout, o_overflow}, 0);

        // single write
        push_one(7'h66, 1'b0, 8'hE3);
        check("sw_empty", o_empty, 0);
        check("sw_count", o_count, 1);
        check("sw_en_early", o_enable, 0);
        step();
        check("sw_en_lat", o_enable, 1);
        serve(2, 40, 7'h66, 1'b0, 8'hE3);
        check("sw_empty_after", o_empty, 1);

        // back-to-back
        push_one(7'h11, 1'b0, 8'h01);
        push_one(7'h22, 1'b1, 8'h02);
        push_one(7'h33, 1'b0, 8'h03);
        serve(1, 5, 7'h11, 1'b0, 8'h01);
        serve(0, 3, 7'h22, 1'b1, 8'h02);
        serve(3, 4, 7'h33, 1'b0, 8'h03);
        check("b2b_empty", o_empty, 1);

        // overflow with master held busy
        i_busy = 1'b1;
        push_one(7'h41, 1'b0, 8'h41);
        push_one(7'h42, 1'b0, 8'h42);
        push_one(7'h43, 1'b0, 8'h43);
        push_one(7'h44, 1'b0, 8'h44);
        check("ov_full", o_full, 1);
        check("ov_count4", o_count, 4);
        check("ov_none", o_overflow, 0);
        push_one(7'h45, 1'b0, 8'h45);
        check("ov_pulse", o_overflow, 1);
        check("ov_count", o_count, 4);
        step();
        check("ov_pulse_end", o_overflow, 0);
        i_busy = 1'b0;
        step();
        check("ov_done1", o_done, 1);
        check("ov_count3", o_count, 3);
        serve(1, 2, 7'h42, 1'b0, 8'h42);
        serve(1, 2, 7'h43, 1'b0, 8'h43);
        serve(1, 2, 7'h44, 1'b0, 8'h44);
        check("ov_empty", o_empty, 1);

        // timeout with busy tied low
        push_one(7'h55, 1'b1, 8'h5A);
        step();
        n = 0;
        while (o_enable && n < 40) begin
            n++;
            step();
        end
        check("to_en_cycles", n, 16);
        check("to_pulse", o_timeout, 1);
        check("to_no_done", o_done, 0);
        check("to_count", o_count, 0);
        step();
        check("to_pulse_end", o_timeout, 0);
        check("to_empty", o_empty, 1);

        // reset during WAIT_DONE with two entries queued
        i_busy = 1'b1;
        push_one(7'h61, 1'b0, 8'h61);
        push_one(7'h62, 1'b0, 8'h62);
        step();
        step();
        check("mr_count", o_count, 2);
        check("mr_addr", o_address, 7'h61);
        i_rst_n = 1'b0;
        step();
        check("mr_enable", o_enable, 0);
        check("mr_outs", {o_address, o_rw, o_data}, 0);
        check("mr_count0", o_count, 0);
        check("mr_empty", o_empty, 1);
        check("mr_flags", {o_done, o_timeout, o_overflow, o_full}, 0);
        i_rst_n = 1'b1;
        i_busy  = 1'b0;
        step();
        check("mr_no_done", o_done, 0);
        check("mr_idle", o_enable, 0);

        // wrap-around order
        for (int i = 0; i < 10; i++) begin
            push_one(7'(8'h10 + i), i[0], 8'(8'hA0 + i));
            serve(1, 2, 7'(8'h10 + i), i[0], 8'(8'hA0 + i));
        end
        check("wrap_empty", o_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
